// File: rtl/ext_sum_acc.sv
// Streaming multi-channel accumulator with per-packet zero/sign extension of operands.
// Define EXT_SUM_SAT_EN to clamp the stored sum on overflow instead of wrapping.
module ext_sum_acc #(
    parameter int IN_W     = 15,
    parameter int ACC_W    = 17,
    parameter int CHANNELS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [CHANNELS*IN_W-1:0] in_data_i,
    input  logic                     in_signed_i,
    input  logic                     in_last_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ACC_W-1:0]         out_sum_o,
    output logic                     out_overflow_o
);

    // state | meaning
    // IDLE  | no partial sum held
    // ACCUM | partial sum held, packet in progress
    // HOLD  | result presented on the output
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} stateT;

    localparam int FULL_W = ACC_W + $clog2(CHANNELS + 1);

    stateT              state;
    logic [ACC_W-1:0]   accReg;
    logic               modeSigned;
    logic               packetOvf;

    logic               accept;
    logic               firstBeat;
    logic               beatSigned;
    logic [FULL_W-1:0]  fullSum;
    logic [FULL_W-ACC_W:0] topBits;
    logic               beatOvf;
    logic               nextOvf;
    logic [ACC_W-1:0]   nextAcc;

    assign in_ready_o = (state != HOLD) || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign firstBeat  = (state != ACCUM);
    assign beatSigned = firstBeat ? in_signed_i : modeSigned;

    always_comb begin
        fullSum = '0;
        if (!firstBeat) begin
            fullSum = {{(FULL_W-ACC_W){beatSigned & accReg[ACC_W-1]}}, accReg};
        end
        for (int k = 0; k < CHANNELS; k++) begin
            fullSum = fullSum + {{(FULL_W-IN_W){beatSigned & in_data_i[k*IN_W + IN_W - 1]}},
                                 in_data_i[k*IN_W +: IN_W]};
        end
    end

    // Signed results fit only when every bit from ACC_W-1 upward agrees.
    assign topBits = fullSum[FULL_W-1:ACC_W-1];
    assign beatOvf = beatSigned ? !((&topBits) || (~|topBits))
                                : (|fullSum[FULL_W-1:ACC_W]);
    assign nextOvf = beatOvf || (!firstBeat && packetOvf);

    always_comb begin
        nextAcc = fullSum[ACC_W-1:0];
`ifdef EXT_SUM_SAT_EN
        if (beatOvf) begin
            if (!beatSigned) begin
                nextAcc = '1;
            end else if (fullSum[FULL_W-1]) begin
                nextAcc = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                nextAcc = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            accReg         <= '0;
            modeSigned     <= 1'b0;
            packetOvf      <= 1'b0;
            out_valid_o    <= 1'b0;
            out_sum_o      <= '0;
            out_overflow_o <= 1'b0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (accept) begin
                accReg     <= nextAcc;
                modeSigned <= beatSigned;
                packetOvf  <= nextOvf;
                if (in_last_i) begin
                    out_sum_o      <= nextAcc;
                    out_overflow_o <= nextOvf;
                    out_valid_o    <= 1'b1;
                    state          <= HOLD;
                end else begin
                    state <= ACCUM;
                end
            end else if (state == HOLD && out_ready_i) begin
                state <= IDLE;
            end
        end
    end

endmodule
